// File: rtl/twelve_hour_timekeeper.sv
// twelve_hour_timekeeper
//   Time-of-day core for a 12-hour clock. Counts BCD seconds, minutes and
//   hours (12, 01 .. 11), tracks AM/PM and lets the user set the time
//   with single-cycle increment pulses while set_mode is high.
//
// Ports
//   clk       system clock
//   rst       synchronous reset, active high -> 12:00:00 AM
//   run       1 = time advances, 0 = frozen (prescaler held at 0)
//   set_mode  1 = setting: seconds forced to 00, counting paused
//   inc_hour  hour +1 per cycle high (set_mode only)
//   inc_min   minute +1 per cycle high, no hour carry (set_mode only)
//   bcd_time  {hour_tens, hour_ones, min_tens, min_ones}
//   bcd_sec   {sec_tens, sec_ones}
//   pm        0 = AM, 1 = PM
//   sec_tick  one-cycle pulse on every counted seconds advance
module twelve_hour_timekeeper #(
    parameter int unsigned TICK_DIV = 100000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        set_mode,
    input  logic        inc_hour,
    input  logic        inc_min,
    output logic [15:0] bcd_time,
    output logic [7:0]  bcd_sec,
    output logic        pm,
    output logic        sec_tick
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] pre_q, pre_d;
    logic [7:0]    hr_q, hr_d;
    logic [7:0]    min_q, min_d;
    logic [7:0]    sec_q, sec_d;
    logic          pm_q, pm_d;
    logic          tick_q, tick_d;

    // {carry, next} for a two-digit BCD 00..59 counter
    function automatic logic [8:0] inc60(input logic [7:0] v);
        logic [8:0] r;
        if (v[3:0] == 4'd9) begin
            if (v[7:4] == 4'd5) r = {1'b1, 8'h00};
            else                r = {1'b0, v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {1'b0, v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    // {toggle_pm, next} for the 12, 01 .. 11 hour sequence
    function automatic logic [8:0] inc_hr(input logic [7:0] h);
        logic [8:0] r;
        case (h)
            8'h11:   r = {1'b1, 8'h12};
            8'h12:   r = {1'b0, 8'h01};
            8'h09:   r = {1'b0, 8'h10};
            default: r = {1'b0, h[7:4], h[3:0] + 4'd1};
        endcase
        return r;
    endfunction

    logic [8:0] sec_nx, min_nx, hr_nx;
    assign sec_nx = inc60(sec_q);
    assign min_nx = inc60(min_q);
    assign hr_nx  = inc_hr(hr_q);

    always_comb begin
        pre_d  = '0;
        hr_d   = hr_q;
        min_d  = min_q;
        sec_d  = sec_q;
        pm_d   = pm_q;
        tick_d = 1'b0;
        if (set_mode) begin
            // Setting: seconds parked at 00, the two pulses are independent
            sec_d = 8'h00;
            if (inc_min) min_d = min_nx[7:0];
            if (inc_hour) begin
                hr_d = hr_nx[7:0];
                pm_d = pm_q ^ hr_nx[8];
            end
        end else if (run) begin
            if (pre_q == PRE_LAST) begin
                tick_d = 1'b1;
                sec_d  = sec_nx[7:0];
                if (sec_nx[8]) begin
                    min_d = min_nx[7:0];
                    if (min_nx[8]) begin
                        hr_d = hr_nx[7:0];
                        pm_d = pm_q ^ hr_nx[8];
                    end
                end
            end else begin
                pre_d = pre_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q  <= '0;
            hr_q   <= 8'h12;
            min_q  <= 8'h00;
            sec_q  <= 8'h00;
            pm_q   <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            hr_q   <= hr_d;
            min_q  <= min_d;
            sec_q  <= sec_d;
            pm_q   <= pm_d;
            tick_q <= tick_d;
        end
    end

    assign bcd_time = {hr_q, min_q};
    assign bcd_sec  = sec_q;
    assign pm       = pm_q;
    assign sec_tick = tick_q;

endmodule

// File: tb/tb_twelve_hour_timekeeper.sv
module tb_twelve_hour_timekeeper;
    localparam int TD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1, run = 1'b0, set_mode = 1'b0, inc_hour = 1'b0, inc_min = 1'b0;
    logic [15:0] bcd_time;
    logic [7:0]  bcd_sec;
    logic        pm, sec_tick;

    twelve_hour_timekeeper #(.TICK_DIV(TD)) dut (
        .clk(clk), .rst(rst), .run(run), .set_mode(set_mode),
        .inc_hour(inc_hour), .inc_min(inc_min),
        .bcd_time(bcd_time), .bcd_sec(bcd_sec), .pm(pm), .sec_tick(sec_tick)
    );

    always #5 clk = ~clk;

    int nvec = 0, nerr = 0;

    // Reference: time of day as seconds since midnight (0..86399).
    int m_tod = 0, m_pre = 0;
    bit m_tick = 1'b0;

    function automatic logic [25:0] exp_vec();
        int hh, mm, ss;
        hh = (m_tod / 3600) % 12;
        if (hh == 0) hh = 12;
        mm = (m_tod / 60) % 60;
        ss = m_tod % 60;
        return {4'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10),
                4'(ss / 10), 4'(ss % 10), (m_tod >= 43200), m_tick};
    endfunction

    // Drive one cycle and advance the reference; outputs settle #1 later.
    task automatic step(input bit r, input bit ru, input bit sm, input bit ih, input bit im);
        int mm;
        rst = r; run = ru; set_mode = sm; inc_hour = ih; inc_min = im;
        @(posedge clk);
        if (r) begin
            m_tod = 0; m_pre = 0; m_tick = 0;
        end else if (sm) begin
            m_pre = 0; m_tick = 0;
            m_tod = m_tod - (m_tod % 60);
            if (im) begin
                mm = (m_tod / 60) % 60;
                m_tod = m_tod + (((mm + 1) % 60) - mm) * 60;
            end
            if (ih) m_tod = (m_tod + 3600) % 86400;
        end else if (ru) begin
            if (m_pre == TD - 1) begin
                m_pre = 0; m_tick = 1; m_tod = (m_tod + 1) % 86400;
            end else begin
                m_pre++; m_tick = 0;
            end
        end else begin
            m_pre = 0; m_tick = 0;
        end
        #1;
    endtask

    // Stimulus only: reset, then dial in h24:mn in set mode.
    task automatic preset(input int h24, input int mn);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < h24; i++) step(0, 0, 1, 1, 0);
        for (int i = 0; i < mn; i++)  step(0, 0, 1, 0, 1);
    endtask

    task automatic test_reset();
        step(1, 1, 0, 0, 0);
        nvec++;
        if ({bcd_time, bcd_sec, pm, sec_tick} !== {16'h1200, 8'h00, 1'b0, 1'b0}) begin
            nerr++;
            $display("FAIL reset: got %h/%h pm=%b tick=%b want 1200/00 pm=0 tick=0",
                     bcd_time, bcd_sec, pm, sec_tick);
        end
    endtask

    task automatic test_tick_rate();
        step(1, 1, 0, 0, 0);
        for (int i = 1; i <= 12; i++) begin
            step(0, 1, 0, 0, 0);
            nvec++;
            if ({bcd_time, bcd_sec, pm, sec_tick} !== exp_vec()) begin
                nerr++;
                $display("FAIL tick_rate c%0d: got %h want %h", i,
                         {bcd_time, bcd_sec, pm, sec_tick}, exp_vec());
            end
            if (i == 4) begin
                nvec++;
                if ({sec_tick, bcd_sec} !== 9'h101) begin
                    nerr++;
                    $display("FAIL first_tick: got tick=%b sec=%h want tick=1 sec=01", sec_tick, bcd_sec);
                end
            end
        end
    endtask

    task automatic test_rollover();
        preset(11, 59);
        for (int i = 1; i <= 60 * TD; i++) begin
            step(0, 1, 0, 0, 0);
            nvec++;
            if ({bcd_time, bcd_sec, pm, sec_tick} !== exp_vec()) begin
                nerr++;
                $display("FAIL rollover c%0d: got %h want %h", i,
                         {bcd_time, bcd_sec, pm, sec_tick}, exp_vec());
            end
            if (i == 59 * TD) begin
                nvec++;
                if ({bcd_time, bcd_sec, pm} !== {24'h115959, 1'b0}) begin
                    nerr++;
                    $display("FAIL pre_roll: got %h%h pm=%b want 115959 pm=0", bcd_time, bcd_sec, pm);
                end
            end
        end
        nvec++;
        if ({bcd_time, bcd_sec, pm, sec_tick} !== {24'h120000, 1'b1, 1'b1}) begin
            nerr++;
            $display("FAIL roll_1200: got %h%h pm=%b tick=%b want 120000 pm=1 tick=1",
                     bcd_time, bcd_sec, pm, sec_tick);
        end
    endtask

    task automatic test_hour_edges();
        preset(12, 59);
        for (int i = 0; i < 60 * TD; i++) step(0, 1, 0, 0, 0);
        nvec++;
        if ({bcd_time, bcd_sec, pm} !== {24'h010000, 1'b1}) begin
            nerr++;
            $display("FAIL h12_to_01: got %h%h pm=%b want 010000 pm=1", bcd_time, bcd_sec, pm);
        end
        preset(9, 59);
        for (int i = 0; i < 60 * TD; i++) step(0, 1, 0, 0, 0);
        nvec++;
        if ({bcd_time, bcd_sec, pm} !== {24'h100000, 1'b0}) begin
            nerr++;
            $display("FAIL h09_to_10: got %h%h pm=%b want 100000 pm=0", bcd_time, bcd_sec, pm);
        end
    endtask

    task automatic test_set_mode();
        logic [16:0] want [5];
        want = '{{16'h1000, 1'b0}, {16'h1100, 1'b0}, {16'h1200, 1'b1},
                 {16'h0101, 1'b1}, {16'h0201, 1'b1}};
        preset(10, 59);
        nvec++;
        if ({bcd_time, pm} !== {16'h1059, 1'b0}) begin
            nerr++;
            $display("FAIL set_preset: got %h pm=%b want 1059 pm=0", bcd_time, pm);
        end
        for (int i = 0; i < 5; i++) begin
            // min wrap, hour, hour (pm toggle), both together, then a held hour pulse
            step(0, 1, 1, (i != 0), (i == 0 || i == 3));
            nvec++;
            if ({bcd_time, pm} !== want[i] || sec_tick !== 1'b0 || bcd_sec !== 8'h00) begin
                nerr++;
                $display("FAIL set_step%0d: got %h pm=%b sec=%h tick=%b want %h pm=%b sec=00 tick=0",
                         i, bcd_time, pm, bcd_sec, sec_tick, want[i][16:1], want[i][0]);
            end
        end
    endtask

    task automatic test_run_hold();
        preset(3, 15);
        for (int i = 0; i < 7 * TD; i++) step(0, 1, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 0, 0, 0);
            nvec++;
            if ({bcd_time, bcd_sec, sec_tick} !== {24'h031507, 1'b0}) begin
                nerr++;
                $display("FAIL hold c%0d: got %h%h tick=%b want 031507 tick=0", i, bcd_time, bcd_sec, sec_tick);
            end
        end
        for (int i = 1; i <= TD; i++) begin
            step(0, 1, 0, 0, 0);
            nvec++;
            if ({sec_tick, bcd_sec} !== ((i == TD) ? 9'h108 : 9'h007)) begin
                nerr++;
                $display("FAIL resume c%0d: got tick=%b sec=%h", i, sec_tick, bcd_sec);
            end
        end
        for (int i = 0; i < 6; i++) begin
            step(0, i[0], 0, 1, 1);
            nvec++;
            if (bcd_time !== 16'h0315 || {bcd_time, bcd_sec, pm, sec_tick} !== exp_vec()) begin
                nerr++;
                $display("FAIL inc_ignored c%0d: got %h want %h", i,
                         {bcd_time, bcd_sec, pm, sec_tick}, exp_vec());
            end
        end
    endtask

    task automatic test_reset_mid();
        preset(19, 42);
        for (int i = 0; i < 33 * TD; i++) step(0, 1, 0, 0, 0);
        nvec++;
        if ({bcd_time, bcd_sec, pm} !== {24'h074233, 1'b1}) begin
            nerr++;
            $display("FAIL mid_preset: got %h%h pm=%b want 074233 pm=1", bcd_time, bcd_sec, pm);
        end
        step(1, 1, 0, 1, 1);
        nvec++;
        if ({bcd_time, bcd_sec, pm, sec_tick} !== {24'h120000, 1'b0, 1'b0}) begin
            nerr++;
            $display("FAIL mid_reset: got %h%h pm=%b tick=%b want 120000 pm=0 tick=0",
                     bcd_time, bcd_sec, pm, sec_tick);
        end
    endtask

    task automatic test_random();
        bit sm = 1'b0;
        step(1, 1, 0, 0, 0);
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(63) == 0) sm = ~sm;
            step(($urandom_range(799) == 0), ($urandom_range(3) != 0), sm,
                 ($urandom_range(3) == 0), ($urandom_range(2) == 0));
            nvec++;
            if ({bcd_time, bcd_sec, pm, sec_tick} !== exp_vec()) begin
                nerr++;
                $display("FAIL random c%0d: got %h want %h", i,
                         {bcd_time, bcd_sec, pm, sec_tick}, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_tick_rate();
        test_rollover();
        test_hour_edges();
        test_set_mode();
        test_run_hold();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/twelve_hour_timekeeper.md
Name: twelve_hour_timekeeper

Overview:
- Time-of-day core of the 12-hour clock.
- Counts seconds, minutes and hours in BCD, tracks AM/PM, and supports user time-setting through single-cycle button pulses.
- Drives the 16-bit packed HH:MM BCD word directly into the seven-segment display controller's bcd_input.
- Also exports seconds and a 1 Hz tick for blink/colon logic.

Parameters:
- TICK_DIV, 100000000, clk cycles per second (range 2..2^27); benches override with a small value.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- run  input  1  1 = time advances; 0 = time frozen and prescaler held
- set_mode  input  1  1 = setting mode; counting is paused and inc pulses are honoured
- inc_hour  input  1  single-cycle pulse (debounced upstream); advances hour by one
- inc_min  input  1  single-cycle pulse; advances minute by one
- bcd_time  output  16  {hour_tens, hour_ones, min_tens, min_ones}, 4 bits each; [15:13] always 0
- bcd_sec  output  8  {sec_tens, sec_ones}
- pm  output  1  0 = AM, 1 = PM
- sec_tick  output  1  one-cycle pulse coincident with every counted seconds advance

Behaviour:
- Reset (rst=1 at a clk edge): bcd_time=16'h1200, bcd_sec=8'h00, pm=0, sec_tick=0, prescaler=0. rst overrides every other input.
- Prescaler:
  - Counts 0..TICK_DIV-1 while run=1 and set_mode=0; otherwise it holds at 0.
  - At the edge where prescaler==TICK_DIV-1 and counting is enabled: prescaler wraps to 0, the seconds advance, and sec_tick is registered 1 for exactly one cycle.
  - sec_tick and the updated time values become visible together after that same edge.
  - First advance occurs TICK_DIV cycles after counting is enabled from a held prescaler.
- Seconds: BCD ones 0..9 with carry into tens; tens 0..5. 59 -> 00 generates a minute carry in the same cycle.
- Minutes: same BCD rule, 00..59. 59 -> 00 with a carry generates an hour carry in the same cycle.
- Hours: sequence 12, 01, 02 ... 11, 12.
  - 11 -> 12 toggles pm.
  - 12 -> 01 does not toggle pm.
  - 09 -> 10 sets hour_tens=1, hour_ones=0.
  - Full rollover 11:59:59 -> 12:00:00 toggles pm on a single edge.
- Setting mode (set_mode=1):
  - Seconds are cleared to 00 on every cycle.
  - Prescaler is held at 0 and sec_tick stays 0.
  - inc_min: minute +1, 59 -> 00, with no carry into hour.
  - inc_hour: hour +1 using the same 12-hour sequence, including the pm toggle at 11 -> 12.
  - inc_hour and inc_min in the same cycle are both applied on that edge.
  - A pulse held high for N cycles increments N times (debounce and one-shot are upstream responsibilities).
- Outside setting mode, inc_hour and inc_min are ignored.
- Leaving setting mode: counting resumes from ss=00; the first tick arrives TICK_DIV cycles later (when run=1).
- Digit legality: all BCD digits stay legal at all times (never A–F). Hour is never 00 and never above 12.
- Outputs are registered; there is no combinational path from inputs to outputs.
- Reset asserted mid-count or mid-set returns to 12:00:00 AM on that edge.

Test Plan:
- TICK_DIV=4; release rst with run=1, set_mode=0 -> bcd_time=16'h1200, pm=0; sec_tick first pulses 4 cycles later with bcd_sec=8'h01; pulses recur every 4 cycles.
- Preset via set mode to 11:59, exit, run 59 ticks then 1 more -> bcd_time=16'h1200, bcd_sec=8'h00, pm=1 on the same edge as the 60th tick.
- From 12:59:59 PM, one tick -> bcd_time=16'h0100, pm stays 1. From 09:59:59, one tick -> bcd_time=16'h1000.
- set_mode=1 at 10:59; pulse inc_min -> 10:00 (hour unchanged); pulse inc_hour twice -> 12:00 with pm toggled once; inc_hour and inc_min in the same cycle at 12:00 -> 01:01.
- run=0 for 20 cycles at 03:15:07 -> time unchanged, sec_tick=0; run=1 -> next advance exactly 4 cycles later. inc pulses with set_mode=0 -> no change.
- Assert rst for one cycle during counting at 07:42:33 PM -> next cycle shows 16'h1200, bcd_sec=00, pm=0, sec_tick=0.
